// File: rtl/ooc_stim_harness.sv
// ooc_stim_harness: out-of-context wrapper. A Galois LFSR drives the DUT inputs.
// A MISR compacts the DUT outputs into a signature, which is shifted out serially.
//
// state | meaning
// IDLE  | waiting for start; seed may be loaded
// RUN   | LFSR and MISR step once per cycle for RUN_LEN cycles
// SHIFT | signature shifted out MSB first, one bit per cycle
// DONE  | signature complete; seed may be loaded, start re-runs
module ooc_stim_harness #(
  parameter int                IN_W    = 8,
  parameter int                OUT_W   = 8,
  parameter int                LFSR_W  = 32,
  parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(32'h0040_0007),
  parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(32'h0000_0001),
  parameter int                MISR_W  = 32,
  parameter logic [MISR_W-1:0] MTAPS   = MISR_W'(32'h0400_0007),
  parameter int                RUN_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              sig_bit,
  output logic              sig_valid,
  output logic              busy,
  output logic              done
);

  localparam int RC_W  = $clog2(RUN_LEN + 1);
  localparam int SC_W  = (MISR_W > 1) ? $clog2(MISR_W) : 1;
  localparam int NCH   = (OUT_W + MISR_W - 1) / MISR_W;
  localparam logic [RC_W-1:0] RUN_LAST   = RC_W'(RUN_LEN - 1);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(MISR_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [MISR_W-1:0] misr, misr_nxt, misr_step, fold;
  logic [RC_W-1:0]   run_cnt, run_nxt;
  logic [SC_W-1:0]   shift_cnt, shift_nxt;
  logic [NCH*MISR_W-1:0] padded;

  assign lfsr_step = {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? TAPS : '0);
  assign misr_step = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MTAPS : '0) ^ fold;

  // Zero-pad the DUT response and XOR all MISR-width chunks together.
  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = dut_out;
    fold = '0;
    for (int c = 0; c < NCH; c++) fold = fold ^ padded[c*MISR_W +: MISR_W];
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    misr_nxt  = misr;
    run_nxt   = run_cnt;
    shift_nxt = shift_cnt;
    case (state)
      IDLE, DONE: begin
        if (seed_load) lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        if (start) begin
          state_nxt = RUN;
          misr_nxt  = '0;
          run_nxt   = '0;
        end
      end
      RUN: begin
        lfsr_nxt = lfsr_step;
        misr_nxt = misr_step;
        run_nxt  = run_cnt + RC_W'(1);
        if (run_cnt == RUN_LAST) begin
          state_nxt = SHIFT;
          shift_nxt = '0;
        end
      end
      SHIFT: begin
        // Wraps to zero on the last bit; the value is unused in DONE.
        shift_nxt = shift_cnt + SC_W'(1);
        if (shift_cnt == SHIFT_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      misr      <= '0;
      run_cnt   <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      misr      <= misr_nxt;
      run_cnt   <= run_nxt;
      shift_cnt <= shift_nxt;
    end
  end

  // The signature is read by index, so the MISR keeps its value after readout.
  assign dut_in    = lfsr[IN_W-1:0];
  assign busy      = (state == RUN) || (state == SHIFT);
  assign done      = (state == DONE);
  assign sig_valid = (state == SHIFT);
  assign sig_bit   = sig_valid & misr[SHIFT_LAST - shift_cnt];

endmodule

// File: doc/ooc_stim_harness.md
# ooc_stim_harness

Parametrised out-of-context test harness that wraps a DUT (the `mctrl`-style OOC designs) so it can be placed, routed and bitstreamed without the tools trimming logic. A Galois LFSR drives every DUT input, and a MISR compacts every DUT output into a signature. The signature is shifted out on one pin, so the top level needs only a handful of pads. It generalises the single-bit random wrapper to arbitrary stimulus/response widths, a programmable seed, a bounded run length and serial signature readout.

## Interface
Parameters:
- `IN_W`, 8 — DUT input width driven by the harness; must be 1..`LFSR_W`.
- `OUT_W`, 8 — DUT output width absorbed by the harness; any value ≥1.
- `LFSR_W`, 32 — stimulus LFSR width.
- `TAPS`, 32'h0040_0007 — LFSR Galois feedback mask (x^32+x^22+x^2+x+1).
- `SEED`, 32'h0000_0001 — reset/fallback seed; must be nonzero.
- `MISR_W`, 32 — signature width.
- `MTAPS`, 32'h0400_0007 — MISR Galois feedback mask.
- `RUN_LEN`, 1024 — number of RUN cycles per test; must be ≥1.

Ports:
- `clk` in 1 — single clock, all state on rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `start` in 1 — single-cycle pulse; begins a run from IDLE or DONE.
- `seed_load` in 1 — loads `seed_in` into the LFSR (IDLE/DONE only).
- `seed_in` in `LFSR_W` — seed value.
- `dut_in` out `IN_W` — stimulus to DUT, equals `lfsr[IN_W-1:0]`.
- `dut_out` in `OUT_W` — DUT response.
- `sig_bit` out 1 — serial signature, MSB first.
- `sig_valid` out 1 — high while `sig_bit` carries a signature bit.
- `busy` out 1 — high in RUN and SHIFT.
- `done` out 1 — high in DONE.

## Operation
- FSM states: IDLE, RUN, SHIFT, DONE. Reset state is IDLE.
- Reset values:
  - lfsr = `SEED`, misr = 0, counters = 0.
  - `dut_in` = `SEED[IN_W-1:0]`.
  - `sig_bit`, `sig_valid`, `busy`, `done` all 0.
- LFSR step: lfsr ← {lfsr[LFSR_W-2:0],0} ^ (lfsr[LFSR_W-1] ? `TAPS` : 0).
- The LFSR advances only in RUN and holds in all other states.
- Fold: `dut_out` is zero-padded to a multiple of `MISR_W`. fold = XOR of all `MISR_W` chunks.
- MISR step: misr ← {misr[MISR_W-2:0],0} ^ (misr[MISR_W-1] ? `MTAPS` : 0) ^ fold. It steps only in RUN.
- IDLE / DONE:
  - `seed_load`=1 sets lfsr ← `seed_in`; if `seed_in`==0, lfsr ← `SEED` instead.
  - `start`=1 → RUN, with misr ← 0 and run counter ← 0.
  - If `seed_load` and `start` are both asserted, the seed loads and the run starts in the same cycle.
- RUN:
  - Each cycle, step the LFSR, step the MISR with the current `dut_out`, and increment the counter.
  - After `RUN_LEN` steps → SHIFT, with shift counter ← 0.
  - `start` and `seed_load` are ignored.
- SHIFT:
  - Shifts `MISR_W` bits over `MISR_W` cycles, `sig_bit` = misr[MISR_W-1-k] in cycle k, with `sig_valid`=1.
  - Then → DONE. The misr value itself is not destroyed.
  - `start` and `seed_load` are ignored.
- DONE: `done`=1; holds until `start`. The LFSR keeps its end-of-run state, so back-to-back runs continue the sequence unless reseeded.
- Width rules:
  - Run counter is clog2(`RUN_LEN`+1) bits.
  - Shift counter is clog2(`MISR_W`) bits.
  - No wrap occurs within a run.

## Timing
- `dut_in` is registered and changes on the edge that steps the LFSR.
- The DUT sees `dut_in` for one full cycle. The MISR absorbs the `dut_out` present before each RUN edge.
- RUN lasts exactly `RUN_LEN` cycles. `busy` rises on the edge after `start`.
- `sig_valid` is high for exactly `MISR_W` consecutive cycles, starting the cycle after the last RUN cycle.
- `done` rises the cycle after the last shift bit.
- Start-to-`done` latency is `RUN_LEN` + `MISR_W` + 1 cycles.
- `reset` asserted mid-RUN or mid-SHIFT returns all state to reset values immediately (asynchronously). No partial signature is emitted after reset release.

## Test plan
- Reset check: assert `reset` with non-default state → lfsr=1, `dut_in`=8'h01, `sig_valid`/`busy`/`done`=0, state IDLE; verified both mid-cycle (asynchronous) and at release.
- Seed load: `seed_load`=1 with `seed_in`=0 in IDLE → lfsr=`SEED`. Then `seed_in`=32'hDEAD_BEEF → `dut_in`=8'hEF next cycle.
- Stimulus sequence: seed 1, `RUN_LEN`=4, start → `dut_in` = 02, 04, 08, 10 on successive RUN edges. LFSR frozen at 0x10 afterwards.
- Signature: `RUN_LEN`=3, `dut_out` tied to 8'h01 → misr 0→1→3→7. Serial readout is 29 zeros then 1,1,1 with `sig_valid` high for 32 cycles; `done` at cycle 3+32+1 after start.
- Ignored controls: pulse `start` and `seed_load` during RUN and SHIFT → run length, LFSR sequence and signature identical to an undisturbed run.
- Reset mid-SHIFT (after 10 bits) → `sig_valid` drops immediately, state IDLE, misr=0. A new start reproduces the reference signature for the same seed.
